// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the mux_seq_scan channel multiplexer/sequencer.
package mux_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    // Data presented when the manual select points past the last channel.
    localparam logic [31:0] OOR_DATA = 32'h0000_0000;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_seq_find.sv
// Combinational first-set search over the latched scan mask, starting at ptr.
// With MUX_SEQ_SCAN_WRAP_EN defined the search falls back to the lowest set bit overall.
module mux_seq_find
    import mux_seq_pkg::*;
#(
    parameter int NCH  = 16,
    parameter int SELW = idx_w(NCH)
) (
    input  logic [NCH-1:0]  mask,
    input  logic [SELW:0]   ptr,
    output logic            found,
    output logic [SELW-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Descending walk so the lowest qualifying index is written last.
        for (int k = NCH - 1; k >= 0; k--) begin
            if (mask[k] && (k >= int'(ptr))) begin
                found = 1'b1;
                idx   = SELW'(k);
            end
        end
`ifdef MUX_SEQ_SCAN_WRAP_EN
        if (!found) begin
            for (int k = NCH - 1; k >= 0; k--) begin
                if (mask[k]) begin
                    found = 1'b1;
                    idx   = SELW'(k);
                end
            end
        end
`endif
    end

endmodule

// File: rtl/mux_seq_scan.sv
// N-channel W-bit registered multiplexer with manual select and masked scan sequencer.
// Optional build macro: MUX_SEQ_SCAN_WRAP_EN (scan wraps to channel 0 until stopped).
module mux_seq_scan
    import mux_seq_pkg::*;
#(
    parameter int NCH  = 16,
    parameter int W    = 8,
    parameter int SELW = idx_w(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH*W-1:0] in_data,
    input  logic [NCH-1:0]   in_mask,
    input  logic             mode,
    input  logic [SELW-1:0]  sel_man,
    input  logic             start,
    input  logic             stop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [SELW-1:0]  out_ch,
    output logic             busy,
    output logic             done
);

    state_e          state_q, state_d;
    logic [SELW:0]   ptr_q, ptr_d;
    logic [NCH-1:0]  mask_q, mask_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;
    logic            done_q, done_d;

    logic            find_found;
    logic [SELW-1:0] find_idx;
    logic            slot_free;
    logic            load;
    logic [SELW-1:0] load_ch;

    // Selects above NCH-1 fall through to the out-of-range constant.
    function automatic logic [W-1:0] pick(input logic [NCH*W-1:0] bus,
                                          input logic [SELW-1:0]  ch);
        logic [W-1:0] val;
        val = OOR_DATA[W-1:0];
        for (int k = 0; k < NCH; k++) begin
            if (int'(ch) == k) val = bus[k*W +: W];
        end
        return val;
    endfunction

    mux_seq_find #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_find (
        .mask  (mask_q),
        .ptr   (ptr_q),
        .found (find_found),
        .idx   (find_idx)
    );

    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        mask_d      = mask_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        done_d      = 1'b0;
        load        = 1'b0;
        load_ch     = sel_man;

        case (state_q)
            IDLE: begin
                if (!mode) begin
                    load = slot_free;
                end else begin
                    // A pending manual sample drains; nothing new is loaded.
                    if (slot_free) out_valid_d = 1'b0;
                    if (start) begin
                        mask_d  = in_mask;
                        ptr_d   = '0;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (slot_free) begin
                    if (stop || !find_found) begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        out_valid_d = 1'b0;
                    end else begin
                        load    = 1'b1;
                        load_ch = find_idx;
                        ptr_d   = {1'b0, find_idx} + (SELW + 1)'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            out_valid_d = 1'b1;
            out_ch_d    = load_ch;
            out_data_d  = pick(in_data, load_ch);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign busy      = (state_q == SCAN);
    assign done      = done_q;

endmodule

// File: tb/tb_mux_seq_scan.sv
// Self-checking bench for mux_seq_scan: manual streaming, scans, back-pressure, stop/wrap, reset.
module tb_mux_seq_scan;

    localparam int NCH  = 16;
    localparam int W    = 8;
    localparam int SELW = 4;
`ifdef MUX_SEQ_SCAN_WRAP_EN
    localparam int PASSES = 64;
`else
    localparam int PASSES = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH*W-1:0] in_data;
    logic [NCH-1:0]   in_mask;
    logic             mode;
    logic [SELW-1:0]  sel_man;
    logic             start;
    logic             stop;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [SELW-1:0]  out_ch;
    logic             busy;
    logic             done;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] cv [NCH];

    mux_seq_scan #(.NCH(NCH), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .mode      (mode),
        .sel_man   (sel_man),
        .start     (start),
        .stop      (stop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_chan(input bit rnd);
        for (int k = 0; k < NCH; k++) begin
            cv[k] = rnd ? W'($urandom) : W'(8'h10 + k);
            in_data[k*W +: W] = cv[k];
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b0; start = 1'b0; stop = 1'b0;
        out_ready = 1'b1; sel_man = '0; in_mask = '0;
        load_chan(1'b0);
        tick(); tick();
        tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset: got valid=%0b data=%h ch=%0d busy=%0b done=%0b, want all zero",
                     out_valid, out_data, out_ch, busy, done);
        end
    endtask

    task automatic test_manual();
        logic          ev;
        logic [W-1:0]  ed;
        logic [SELW-1:0] ec;
        mode = 1'b0; sel_man = 4'd5; out_ready = 1'b1; rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_data !== 8'h15 || out_ch !== 4'd5) begin
                fails++;
                $display("FAIL manual_fixed[%0d]: got valid=%0b data=%h ch=%0d, want 1/15/5",
                         i, out_valid, out_data, out_ch);
            end
        end
        ev = 1'b1; ed = 8'h15; ec = 4'd5;
        for (int i = 0; i < 200; i++) begin
            load_chan(1'b1);
            sel_man   = SELW'($urandom_range(0, NCH - 1));
            out_ready = 1'($urandom_range(0, 1));
            if (!ev || out_ready) begin
                ev = 1'b1; ed = cv[sel_man]; ec = sel_man;
            end
            tick();
            tests++;
            if (out_valid !== ev || out_data !== ed || out_ch !== ec) begin
                fails++;
                $display("FAIL manual_rand[%0d]: got valid=%0b data=%h ch=%0d, want %0b/%h/%0d",
                         i, out_valid, out_data, out_ch, ev, ed, ec);
            end
        end
    endtask

    // rmode: 0 ready always high, 1 random ready, 2 ready low 3 cycles after first sample
    task automatic run_scan(input string name, input logic [NCH-1:0] mask, input int stop_after,
                            input int rmode, input bit rnd_ctl);
        int   exp_list[$];
        int   acc, cyc, bp;
        bit   dn, seen;
        logic pv, pr;
        logic [W-1:0]    pd;
        logic [SELW-1:0] pc;

        for (int r = 0; r < PASSES && exp_list.size() < stop_after; r++)
            for (int k = 0; k < NCH; k++)
                if (mask[k] && exp_list.size() < stop_after) exp_list.push_back(k);

        mode = 1'b1; out_ready = 1'b1; stop = 1'b0; start = 1'b0;
        tick(); tick();
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s pre_scan: got valid=%0b busy=%0b, want 0/0", name, out_valid, busy);
        end
        in_mask = mask; start = 1'b1;
        tick();
        start = 1'b0; in_mask = NCH'($urandom);
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL %s busy_rise: got busy=%0b done=%0b, want 1/0", name, busy, done);
        end

        acc = 0; cyc = 1; bp = 0; dn = 1'b0; seen = 1'b0;
        while (!dn && cyc < 400) begin
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (seen && out_valid && bp < 3) begin
                        out_ready = 1'b0; bp++;
                    end else out_ready = 1'b1;
                end
            endcase
            stop = (acc + ((out_valid && out_ready) ? 1 : 0)) >= stop_after;
            if (rnd_ctl) begin
                mode  = 1'($urandom_range(0, 1));
                start = 1'($urandom_range(0, 1));
            end
            pv = out_valid; pr = out_ready; pd = out_data; pc = out_ch;
            tick();
            cyc++;
            if (pv && pr) begin
                tests++;
                if (acc >= exp_list.size()) begin
                    fails++;
                    $display("FAIL %s extra_sample: got ch=%0d after %0d samples, want none", name, pc, acc);
                end else if (int'(pc) !== exp_list[acc] || pd !== cv[exp_list[acc]]) begin
                    fails++;
                    $display("FAIL %s sample[%0d]: got ch=%0d data=%h, want ch=%0d data=%h",
                             name, acc, pc, pd, exp_list[acc], cv[exp_list[acc]]);
                end
                acc++;
            end
            if (pv && !pr) begin
                tests++;
                if (out_valid !== 1'b1 || out_data !== pd || out_ch !== pc) begin
                    fails++;
                    $display("FAIL %s stall_hold: got valid=%0b data=%h ch=%0d, want 1/%h/%0d",
                             name, out_valid, out_data, out_ch, pd, pc);
                end
            end
            if (rmode == 0 && seen && !done) begin
                tests++;
                if (out_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL %s throughput: got valid=%0b mid-scan, want 1", name, out_valid);
                end
            end
            if (out_valid) seen = 1'b1;
            if (exp_list.size() == 0 && out_valid) begin
                tests++; fails++;
                $display("FAIL %s empty_valid: got valid=1, want 0", name);
            end
            if (done) begin
                dn = 1'b1;
                start = 1'b0; mode = 1'b1; stop = 1'b0;
                tests++;
                if (busy !== 1'b0 || out_valid !== 1'b0 || acc !== exp_list.size()) begin
                    fails++;
                    $display("FAIL %s done_state: got busy=%0b valid=%0b samples=%0d, want 0/0/%0d",
                             name, busy, out_valid, acc, exp_list.size());
                end
                if (mask == '0) begin
                    tests++;
                    if (cyc !== 2) begin
                        fails++;
                        $display("FAIL %s empty_done_time: got cycle %0d, want 2", name, cyc);
                    end
                end
            end else begin
                tests++;
                if (busy !== 1'b1) begin
                    fails++;
                    $display("FAIL %s busy_held: got busy=%0b, want 1", name, busy);
                end
            end
        end
        start = 1'b0; mode = 1'b1; stop = 1'b0;
        if (!dn) begin
            tests++; fails++;
            $display("FAIL %s timeout: got no done in %0d cycles, want done", name, cyc);
        end
        tick();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s done_pulse: got done=%0b busy=%0b after pulse, want 0/0", name, done, busy);
        end
    endtask

    task automatic test_reset_mid_scan();
        int  n;
        bit  hit;
        load_chan(1'b0);
        mode = 1'b1; out_ready = 1'b1; stop = 1'b0;
        tick(); tick();
        in_mask = 16'hFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0; hit = 1'b0;
        while (!hit && n < 40) begin
            if (out_valid && out_ch == 4'd5) hit = 1'b1;
            else begin tick(); n++; end
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL rst_mid reach_ch5: got no ch 5 in %0d cycles, want ch 5", n);
        end
        rst_n = 1'b0;
        tick();
        tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid outputs: got valid=%0b data=%h ch=%0d busy=%0b done=%0b, want all zero",
                     out_valid, out_data, out_ch, busy, done);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL rst_mid after[%0d]: got done=%0b busy=%0b valid=%0b, want 0/0/0",
                         i, done, busy, out_valid);
            end
        end
    endtask

    task automatic test_random_scans();
        logic [NCH-1:0] m;
        for (int i = 0; i < 20; i++) begin
            load_chan(1'b1);
            m = ($urandom_range(0, 5) == 0) ? '0 : NCH'($urandom);
            run_scan("rand_scan", m, $urandom_range(1, 20), $urandom_range(0, 2), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        load_chan(1'b0);
        run_scan("single_pass", 16'h8421, 1000, 0, 1'b0);
        run_scan("back_pressure", 16'h0003, 1000, 2, 1'b0);
        run_scan("empty_mask", 16'h0000, 1000, 0, 1'b0);
        run_scan("stop_wrap", 16'h0006, 3, 0, 1'b0);
        test_reset_mid_scan();
        test_random_scans();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
